// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter (and, later, the receiver).
//   - uart_state_e       : frame FSM state encoding
//   - DATA_BIT/START_BIT : frame geometry
//   - BAUD_MAX_9600_100M : default divisor (9600 baud from a 100 MHz clock)
//   - BAUD_CNT_W         : width of the baud counter; the divisor must fit in it
package uart_pkg;

    localparam int unsigned DATA_BIT           = 8;
    localparam int unsigned START_BIT          = 1;
    localparam int unsigned BAUD_MAX_9600_100M = 10416;
    localparam int unsigned BAUD_CNT_W         = 14;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: enable-gated bit-period counter.
// Counts 0..BAUD_MAX while en is high and wraps; held at 0 while en is low, so the
// first period after en rises is a full BAUD_MAX+1 cycles.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   en      in  count enable; low clears the counter synchronously
//   bit_end out high in the last cycle of each bit period
import uart_pkg::*;

module uart_baud_gen #(
    parameter int unsigned BAUD_MAX = BAUD_MAX_9600_100M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_end
);

    localparam logic [BAUD_CNT_W-1:0] CntMax = BAUD_CNT_W'(BAUD_MAX);

    logic [BAUD_CNT_W-1:0] count_q;

    generate
        if (BAUD_MAX >= (32'd1 << BAUD_CNT_W)) begin : g_baud_max_chk
            $error("uart_baud_gen: BAUD_MAX does not fit in the baud counter");
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (!en) begin
            count_q <= '0;
        end else if (count_q == CntMax) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bit_end = en && (count_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + 8 data bits (LSB first) + optional parity + 1/2 stop.
// Optional feature macro: UART_TX_PARITY_EN (adds a parity bit, even/odd by PARITY_ODD).
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset (abandons any frame, tx high at once)
//   tx_data  in  byte to send, captured at the valid/ready handshake
//   tx_valid in  source has a byte
//   tx_ready out transmitter idle and able to accept a byte
//   tx       out serial line (flop output, idles high)
//   tx_busy  out frame in progress (~tx_ready)
//   tx_done  out one-cycle pulse in the last cycle of the final stop bit
import uart_pkg::*;

module uart_tx #(
    parameter int unsigned BAUD_MAX   = BAUD_MAX_9600_100M,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic       LastStop = (STOP_BITS == 2);
    localparam logic [2:0] LastData = 3'(DATA_BIT - 1);

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD > 1) begin : g_parity_chk
            $error("uart_tx: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        stop_idx_q;
    logic        tx_q;
    logic        ready_q;
    logic        bit_end;

`ifdef UART_TX_PARITY_EN
    localparam logic ParityOdd = PARITY_ODD[0];
    logic parity_q;
`endif

    uart_baud_gen #(
        .BAUD_MAX(BAUD_MAX)
    ) u_baud_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q != StIdle),
        .bit_end(bit_end)
    );

    // tx is loaded one bit ahead at each transition so the pin is always a flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (tx_valid && ready_q) begin
                        shift_q    <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= (^tx_data) ^ ParityOdd;
`endif
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == LastData) begin
`ifdef UART_TX_PARITY_EN
                            tx_q       <= parity_q;
                            state_q    <= StParity;
`else
                            tx_q       <= 1'b1;
                            stop_idx_q <= 1'b0;
                            state_q    <= StStop;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        tx_q       <= 1'b1;
                        stop_idx_q <= 1'b0;
                        state_q    <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        if (stop_idx_q == LastStop) begin
                            ready_q <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = ~ready_q;
    // Decoded from flops: coincides with the final bit_end, so the handshake that
    // follows can only land on the next (idle) cycle.
    assign tx_done  = (state_q == StStop) && bit_end && (stop_idx_q == LastStop);

endmodule
